text_line_writer: RTL and testbench
===================================

TEXT_LINE_WRITER -- requirements
Module: text_line_writer

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 16: character cells in the line (2..64).
REQ-002 SHALL have parameter SCALE, default 1: glyph scale; cell pitch is 6*SCALE pixels.
REQ-003 SHALL have parameters ORIGIN_ROW and ORIGIN_COL, default 0: top-left pixel of cell 0.
REQ-004 SHALL have parameter WRAP, default 0: 1 means the cursor wraps after the last cell; 0 means the writer stops when full.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_l, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port char_in, input, 8: ASCII character offered by the producer.
REQ-008 SHALL have port char_valid, input, 1: char_in is valid.
REQ-009 SHALL have port char_ready, output, 1: the writer accepts char_in this cycle.
REQ-010 SHALL have port clear, input, 1: single-cycle request to blank the whole line.
REQ-011 SHALL have port VGA_row, input, 10: current scan row.
REQ-012 SHALL have port VGA_col, input, 10: current scan column.
REQ-013 SHALL have port character, output, 8: code of the cell under (VGA_row, VGA_col), fed to the glyph renderer.
REQ-014 SHALL have port cell_active, output, 1: the scan position lies inside the line region.
REQ-015 SHALL have port cursor, output, $clog2(NUM_CHARS): index of the next cell to write.
REQ-016 SHALL have port full, output, 1: all cells written and WRAP=0.

Function
REQ-017 SHALL hold the line in an NUM_CHARS x 8-bit register array.
REQ-018 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-019 SHALL drive char_ready = (state==IDLE) && !full && !clear.
REQ-020 SHALL accept a character only on a cycle where char_valid && char_ready.
REQ-021 On acceptance of a printable character, SHALL write char_in to buffer[cursor] and increment cursor at the same edge.
REQ-022 On acceptance at cursor==NUM_CHARS-1 with WRAP=1, SHALL set cursor to 0 and leave full at 0.
REQ-023 On acceptance at cursor==NUM_CHARS-1 with WRAP=0, SHALL hold cursor and set full at the next edge.
REQ-024 On acceptance of 0x08 (backspace) with cursor>0, SHALL decrement cursor, write 0x20 into the new cursor cell, and clear full.
REQ-025 On acceptance of 0x08 with cursor==0, SHALL change nothing; the character is still consumed.
REQ-026 When clear is high in IDLE, SHALL enter CLEAR at the next edge; any coincident char_valid is not accepted.
REQ-027 In CLEAR, SHALL write 0x20 into one cell per cycle, index 0 to NUM_CHARS-1, taking exactly NUM_CHARS cycles.
REQ-028 On the final CLEAR write, SHALL return to IDLE with cursor=0 and full=0.
REQ-029 SHALL ignore clear while already in CLEAR.
REQ-030 SHALL compute character and cell_active combinationally, with zero latency from VGA_row/VGA_col.
REQ-031 SHALL assert cell_active when ORIGIN_ROW <= VGA_row < ORIGIN_ROW+6*SCALE and ORIGIN_COL <= VGA_col < ORIGIN_COL+NUM_CHARS*6*SCALE.
REQ-032 When cell_active, SHALL output character = buffer[(VGA_col-ORIGIN_COL)/(6*SCALE)].
REQ-033 When not cell_active, SHALL output character = 0x20.
REQ-034 SHALL evaluate all region comparisons at 11-bit width so they do not overflow.

Reset
REQ-035 When rst_l is low, SHALL immediately set state=IDLE, cursor=0, full=0, and every buffer cell to 0x20.
REQ-036 Reset asserted mid-CLEAR SHALL abort the sweep; the line is blank after release.
REQ-037 After reset, char_ready SHALL be 1 whenever clear is low.

Structure
REQ-038 SHALL place the FSM state enum, ASCII_SPACE (0x20), ASCII_BS (0x08) and TYPE_WIDTH (6) in a shared display package.
REQ-039 SHALL instantiate one sub-module, text_cell_index, for the combinational pixel-to-cell lookup.

Verification
REQ-040 Reset, then write "AB" (0x41, 0x42) with char_valid held -> cursor=2; character=0x41 at VGA_col=ORIGIN_COL, 0x42 at VGA_col=ORIGIN_COL+6*SCALE.
REQ-041 NUM_CHARS=4, WRAP=0, write 4 chars -> full=1, char_ready=0; a 5th char is not accepted.
REQ-042 NUM_CHARS=4, WRAP=1, write 5 chars -> cursor=1; cell 0 holds the 5th char.
REQ-043 Write "XY", then 0x08 -> cursor=1 and cell 1 = 0x20; 0x08 at cursor=0 -> no change.
REQ-044 clear and char_valid both high in one cycle -> char_ready=0 that cycle; all cells read 0x20 exactly NUM_CHARS cycles later; rst_l pulsed mid-CLEAR -> IDLE, cursor=0.
REQ-045 Scan VGA_col from ORIGIN_COL-1 to the region's right edge -> cell_active goes 0, 1, ..., 1, 0 at the exact boundaries; character=0x20 outside the region.

Source files
------------

// File: rtl/text_line_writer_pkg.sv
// rtl/text_line_writer_pkg.sv - shared display constants, FSM states and helpers
package text_line_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam int         TYPE_WIDTH  = 6;

  // Only 0x20..0x7E land in the line; other control codes are consumed silently.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7e);
  endfunction

endpackage

// File: rtl/text_cell_index.sv
// rtl/text_cell_index.sv - combinational scan-position to character-cell lookup
module text_cell_index
  import text_line_writer_pkg::*;
#(
  parameter int NUM_CHARS  = 16,
  parameter int SCALE      = 1,
  parameter int ORIGIN_ROW = 0,
  parameter int ORIGIN_COL = 0
) (
  input  logic [9:0]                     row,
  input  logic [9:0]                     col,
  output logic                           active,
  output logic [$clog2(NUM_CHARS)-1:0]   index
);

  localparam int CW    = $clog2(NUM_CHARS);
  localparam int PITCH = TYPE_WIDTH * SCALE;

  // Region bounds widened to 11 bits so origin + extent never wraps.
  localparam logic [10:0] ROW_LO  = 11'(ORIGIN_ROW);
  localparam logic [10:0] ROW_HI  = 11'(ORIGIN_ROW + PITCH);
  localparam logic [10:0] COL_LO  = 11'(ORIGIN_COL);
  localparam logic [10:0] COL_HI  = 11'(ORIGIN_COL + NUM_CHARS * PITCH);
  localparam logic [10:0] PITCH11 = 11'(PITCH);

  logic [10:0] row11;
  logic [10:0] col11;
  logic [10:0] offset;

  assign row11  = {1'b0, row};
  assign col11  = {1'b0, col};
  assign active = (row11 >= ROW_LO) && (row11 < ROW_HI) &&
                  (col11 >= COL_LO) && (col11 < COL_HI);
  assign offset = col11 - COL_LO;
  assign index  = active ? CW'(offset / PITCH11) : '0;

endmodule

// File: rtl/text_line_writer.sv
// rtl/text_line_writer.sv - single text line buffer with cursor, backspace and clear sweep
module text_line_writer
  import text_line_writer_pkg::*;
#(
  parameter int NUM_CHARS  = 16,
  parameter int SCALE      = 1,
  parameter int ORIGIN_ROW = 0,
  parameter int ORIGIN_COL = 0,
  parameter int WRAP       = 0
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [7:0]                     char_in,
  input  logic                           char_valid,
  output logic                           char_ready,
  input  logic                           clear,
  input  logic [9:0]                     VGA_row,
  input  logic [9:0]                     VGA_col,
  output logic [7:0]                     character,
  output logic                           cell_active,
  output logic [$clog2(NUM_CHARS)-1:0]   cursor,
  output logic                           full
);

  localparam int            CW   = $clog2(NUM_CHARS);
  localparam logic [CW-1:0] LAST = CW'(NUM_CHARS - 1);

  state_t        state;
  state_t        state_next;
  logic [7:0]    buffer [NUM_CHARS];
  logic [CW-1:0] clr_idx;
  logic [CW-1:0] scan_idx;
  logic          accept;

  assign accept = char_valid && char_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake: clear wins over a coincident character.
  always_comb begin
    state_next = state;
    char_ready = 1'b0;
    case (state)
      IDLE: begin
        char_ready = !full && !clear;
        if (clear) state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_idx == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line storage, cursor and full flag; the clear sweep blanks one cell per cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_CHARS; i++) buffer[i] <= ASCII_SPACE;
      cursor  <= '0;
      full    <= 1'b0;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      buffer[clr_idx] <= ASCII_SPACE;
      clr_idx         <= clr_idx + 1'b1;
      if (clr_idx == LAST) begin
        clr_idx <= '0;
        cursor  <= '0;
        full    <= 1'b0;
      end
    end else if (clear) begin
      clr_idx <= '0;
    end else if (accept) begin
      if (char_in == ASCII_BS) begin
        if (cursor != '0) begin
          cursor                  <= cursor - 1'b1;
          buffer[cursor - 1'b1]   <= ASCII_SPACE;
          full                    <= 1'b0;
        end
      end else if (is_printable(char_in)) begin
        buffer[cursor] <= char_in;
        if (cursor == LAST) begin
          if (WRAP != 0) cursor <= '0;
          else           full   <= 1'b1;
        end else begin
          cursor <= cursor + 1'b1;
        end
      end
    end
  end

  text_cell_index #(
    .NUM_CHARS  (NUM_CHARS),
    .SCALE      (SCALE),
    .ORIGIN_ROW (ORIGIN_ROW),
    .ORIGIN_COL (ORIGIN_COL)
  ) u_cell_index (
    .row    (VGA_row),
    .col    (VGA_col),
    .active (cell_active),
    .index  (scan_idx)
  );

  assign character = cell_active ? buffer[scan_idx] : ASCII_SPACE;

endmodule

// File: tb/tb_text_line_writer.sv
// tb/tb_text_line_writer.sv - randomized self-checking bench for text_line_writer
module tb_text_line_writer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       clear = 1'b0;

  logic [9:0] vga_row_a = '0, vga_col_a = '0, vga_row_b = '0, vga_col_b = '0;
  logic [7:0] character_a, character_b;
  logic       cell_active_a, cell_active_b, ready_a, ready_b, full_a, full_b;
  logic [1:0] cursor_a, cursor_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mbuf [2][N];
  int         mcur [2];
  bit         mfull [2];

  always #5 clk = ~clk;

  text_line_writer #(.NUM_CHARS(N), .SCALE(1), .ORIGIN_ROW(10), .ORIGIN_COL(20), .WRAP(0)) dut_a (
    .clk(clk), .rst_l(rst_l), .char_in(char_in), .char_valid(char_valid), .char_ready(ready_a),
    .clear(clear), .VGA_row(vga_row_a), .VGA_col(vga_col_a), .character(character_a),
    .cell_active(cell_active_a), .cursor(cursor_a), .full(full_a));

  text_line_writer #(.NUM_CHARS(N), .SCALE(2), .ORIGIN_ROW(3), .ORIGIN_COL(100), .WRAP(1)) dut_b (
    .clk(clk), .rst_l(rst_l), .char_in(char_in), .char_valid(char_valid), .char_ready(ready_b),
    .clear(clear), .VGA_row(vga_row_b), .VGA_col(vga_col_b), .character(character_b),
    .cell_active(cell_active_b), .cursor(cursor_b), .full(full_b));

  function automatic int org_row(int k); return (k == 0) ? 10 : 3; endfunction
  function automatic int org_col(int k); return (k == 0) ? 20 : 100; endfunction
  function automatic int pitch(int k);   return (k == 0) ? 6 : 12; endfunction
  function automatic bit wraps(int k);   return k != 0; endfunction

  function automatic logic get_ready(int k);       return (k == 0) ? ready_a : ready_b; endfunction
  function automatic logic get_full(int k);        return (k == 0) ? full_a : full_b; endfunction
  function automatic logic [1:0] get_cursor(int k); return (k == 0) ? cursor_a : cursor_b; endfunction
  function automatic logic [7:0] get_char(int k);  return (k == 0) ? character_a : character_b; endfunction
  function automatic logic get_active(int k);      return (k == 0) ? cell_active_a : cell_active_b; endfunction

  task automatic set_vga(input int k, input int r, input int c);
    if (k == 0) begin vga_row_a = 10'(r); vga_col_a = 10'(c); end
    else        begin vga_row_b = 10'(r); vga_col_b = 10'(c); end
  endtask

  task automatic model_blank();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) mbuf[k][i] = 8'h20;
      mcur[k] = 0;
      mfull[k] = 0;
    end
  endtask

  task automatic model_accept(input int k, input logic [7:0] c);
    if (c == 8'h08) begin
      if (mcur[k] > 0) begin
        mcur[k] = mcur[k] - 1;
        mbuf[k][mcur[k]] = 8'h20;
        mfull[k] = 0;
      end
    end else if (c >= 8'h20 && c <= 8'h7e) begin
      mbuf[k][mcur[k]] = c;
      if (mcur[k] == N - 1) begin
        if (wraps(k)) mcur[k] = 0;
        else          mfull[k] = 1;
      end else begin
        mcur[k] = mcur[k] + 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (get_cursor(k) !== 2'(mcur[k])) begin
        n_fail++; $display("FAIL %s cursor[%0d]: got %0d want %0d", tag, k, get_cursor(k), mcur[k]);
      end
      n_cmp++;
      if (get_full(k) !== mfull[k]) begin
        n_fail++; $display("FAIL %s full[%0d]: got %0b want %0b", tag, k, get_full(k), mfull[k]);
      end
      n_cmp++;
      if (get_ready(k) !== !mfull[k]) begin
        n_fail++; $display("FAIL %s ready[%0d]: got %0b want %0b", tag, k, get_ready(k), !mfull[k]);
      end
      for (int i = 0; i < N; i++) begin
        set_vga(k, org_row(k) + $urandom_range(0, pitch(k) - 1),
                org_col(k) + i * pitch(k) + $urandom_range(0, pitch(k) - 1));
        #1;
        n_cmp++;
        if (get_active(k) !== 1'b1 || get_char(k) !== mbuf[k][i]) begin
          n_fail++;
          $display("FAIL %s cell[%0d][%0d]: got act=%0b ch=%02h want act=1 ch=%02h",
                   tag, k, i, get_active(k), get_char(k), mbuf[k][i]);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] c);
    bit er [2];
    @(posedge clk); #1;
    char_in = c; char_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      er[k] = !mfull[k];
      n_cmp++;
      if (get_ready(k) !== er[k]) begin
        n_fail++; $display("FAIL send ready[%0d] ch=%02h: got %0b want %0b", k, c, get_ready(k), er[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) if (er[k]) model_accept(k, c);
    #1;
    char_valid = 1'b0; char_in = 8'h00;
  endtask

  task automatic do_clear(input bit with_char);
    @(posedge clk); #1;
    clear = 1'b1; char_valid = with_char; char_in = 8'h5a;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (get_ready(k) !== 1'b0) begin
        n_fail++; $display("FAIL clear_req ready[%0d]: got %0b want 0", k, get_ready(k));
      end
    end
    @(posedge clk); #1;
    clear = 1'b0; char_valid = 1'b0;
    for (int c = 1; c <= N; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (get_ready(k) !== 1'b0) begin
          n_fail++; $display("FAIL sweep ready[%0d] cycle %0d: got %0b want 0", k, c, get_ready(k));
        end
      end
      if (c == 2) clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
    end
    model_blank();
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    model_blank();
  endtask

  task automatic test_reset();
    send(8'h51); send(8'h52);
    @(posedge clk); #3;
    rst_l = 1'b0;
    #1;
    model_blank();
    check_state("reset_async");
    @(posedge clk); #1;
    rst_l = 1'b1;
    check_state("reset_release");
  endtask

  task automatic test_ab();
    do_reset();
    send(8'h41); send(8'h42);
    n_cmp++;
    if (cursor_a !== 2'd2) begin n_fail++; $display("FAIL ab cursor: got %0d want 2", cursor_a); end
    set_vga(0, 10, 20); #1;
    n_cmp++;
    if (character_a !== 8'h41) begin n_fail++; $display("FAIL ab cell0: got %02h want 41", character_a); end
    set_vga(0, 10, 26); #1;
    n_cmp++;
    if (character_a !== 8'h42) begin n_fail++; $display("FAIL ab cell1: got %02h want 42", character_a); end
    check_state("ab");
  endtask

  task automatic test_full_wrap();
    logic [7:0] fifth;
    do_reset();
    for (int i = 0; i < N; i++) send(8'($urandom_range(32'h21, 32'h7e)));
    n_cmp++;
    if (full_a !== 1'b1 || ready_a !== 1'b0) begin
      n_fail++; $display("FAIL full_a: got full=%0b rdy=%0b want full=1 rdy=0", full_a, ready_a);
    end
    fifth = 8'($urandom_range(32'h21, 32'h7e));
    send(fifth);
    set_vga(1, 3, 100); #1;
    n_cmp++;
    if (cursor_b !== 2'd1 || character_b !== fifth) begin
      n_fail++; $display("FAIL wrap_b: got cur=%0d cell0=%02h want cur=1 cell0=%02h", cursor_b, character_b, fifth);
    end
    check_state("full_wrap");
  endtask

  task automatic test_backspace();
    do_reset();
    send(8'h58); send(8'h59); send(8'h08);
    set_vga(0, 10, 26); #1;
    n_cmp++;
    if (cursor_a !== 2'd1 || character_a !== 8'h20) begin
      n_fail++; $display("FAIL bs: got cur=%0d cell1=%02h want cur=1 cell1=20", cursor_a, character_a);
    end
    send(8'h08);
    check_state("bs_to_zero");
    send(8'h08);
    check_state("bs_at_zero");
  endtask

  task automatic test_clear();
    do_reset();
    send(8'h31); send(8'h32); send(8'h33);
    do_clear(1'b1);
    check_state("clear_done");
    send(8'h34); send(8'h35);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_l = 1'b0;
    #2;
    rst_l = 1'b1;
    model_blank();
    check_state("reset_mid_clear");
  endtask

  task automatic test_scan();
    for (int k = 0; k < 2; k++) begin
      int lo = org_col(k);
      int hi = org_col(k) + N * pitch(k);
      for (int c = lo - 1; c <= hi; c++) begin
        bit exp_act = (c >= lo) && (c < hi);
        logic [7:0] exp_ch = exp_act ? mbuf[k][(c - lo) / pitch(k)] : 8'h20;
        set_vga(k, org_row(k), c); #1;
        n_cmp++;
        if (get_active(k) !== exp_act || get_char(k) !== exp_ch) begin
          n_fail++;
          $display("FAIL scan[%0d] col %0d: got act=%0b ch=%02h want act=%0b ch=%02h",
                   k, c, get_active(k), get_char(k), exp_act, exp_ch);
        end
      end
      for (int r = 0; r < 3; r++) begin
        int row = (r == 0) ? org_row(k) - 1 : (r == 1) ? org_row(k) + pitch(k) : org_row(k) + pitch(k) - 1;
        bit exp_act = (r == 2);
        logic [7:0] exp_ch = exp_act ? mbuf[k][0] : 8'h20;
        set_vga(k, row, lo); #1;
        n_cmp++;
        if (get_active(k) !== exp_act || get_char(k) !== exp_ch) begin
          n_fail++;
          $display("FAIL scan_row[%0d] row %0d: got act=%0b ch=%02h want act=%0b ch=%02h",
                   k, row, get_active(k), get_char(k), exp_act, exp_ch);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 6)       do_clear(1'($urandom_range(0, 1)));
      else if (r < 25) send(8'h08);
      else             send(8'($urandom_range(32'h20, 32'h7e)));
      if (i % 10 == 9) check_state($sformatf("random_%0d", i));
    end
    test_scan();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_blank();
    #12;
    rst_l = 1'b1;
    test_reset();
    test_ab();
    test_full_wrap();
    test_scan();
    test_backspace();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
